// File: rtl/riscv_machine_timer.sv
// RISC-V machine timer: prescaled 64-bit mtime, mtimecmp compare with registered
// timeout level, periodic auto-reload on interrupt acknowledge.
module riscv_machine_timer #(
    parameter int PRESCALE_W = 8,
    parameter int X_LEN      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_design,
    input  logic             irq_ack,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [X_LEN-1:0] wr_data,
    input  logic [2:0]       rd_idx,
    output logic [X_LEN-1:0] rd_data,
    output logic             timer_timeout
);
    localparam int T_W = 2 * X_LEN;

    logic [T_W-1:0]        mtime;
    logic [T_W-1:0]        mtimecmp;
    logic                  ctrl_en;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] ps_cnt;
    logic [X_LEN-1:0]      reload_period;
    logic                  wrapped;

    logic [7:0]            wr_sel;
    logic                  count_en;
    logic                  tick;
    logic                  mtime_wr;
    logic                  wrap_evt;
    logic [T_W-1:0]        cmp_reload;

    assign wr_sel     = {7'b0, wr_en} << wr_idx;
    assign count_en   = ctrl_en & enable_design;
    assign tick       = count_en && (ps_cnt == prescale);
    assign mtime_wr   = wr_sel[0] | wr_sel[1];
    // A bus write to either mtime half wins over the increment, so no wrap either.
    assign wrap_evt   = tick && !mtime_wr && (&mtime);
    assign cmp_reload = mtimecmp + {{X_LEN{1'b0}}, reload_period};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime         <= '0;
            mtimecmp      <= '1;
            ctrl_en       <= 1'b0;
            auto_reload   <= 1'b0;
            prescale      <= '0;
            ps_cnt        <= '0;
            reload_period <= '0;
            wrapped       <= 1'b0;
            timer_timeout <= 1'b0;
        end else begin
            if (wr_sel[5])
                ps_cnt <= '0;
            else if (count_en)
                ps_cnt <= tick ? '0 : ps_cnt + 1'b1;

            if (mtime_wr) begin
                if (wr_sel[0]) mtime[X_LEN-1:0]   <= wr_data;
                if (wr_sel[1]) mtime[T_W-1:X_LEN] <= wr_data;
            end else if (tick) begin
                mtime <= mtime + 1'b1;
            end

            if (wr_sel[2])
                mtimecmp[X_LEN-1:0] <= wr_data;
            else if (wr_sel[3])
                mtimecmp[T_W-1:X_LEN] <= wr_data;
            else if (irq_ack && auto_reload)
                mtimecmp <= cmp_reload;

            if (wr_sel[4]) begin
                ctrl_en     <= wr_data[0];
                auto_reload <= wr_data[1];
            end
            if (wr_sel[5]) prescale      <= wr_data[PRESCALE_W-1:0];
            if (wr_sel[6]) reload_period <= wr_data;

            wrapped       <= (wrapped & ~(wr_sel[7] & wr_data[1])) | wrap_evt;
            timer_timeout <= ctrl_en && (mtime >= mtimecmp);
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_idx)
            3'd0: rd_data = mtime[X_LEN-1:0];
            3'd1: rd_data = mtime[T_W-1:X_LEN];
            3'd2: rd_data = mtimecmp[X_LEN-1:0];
            3'd3: rd_data = mtimecmp[T_W-1:X_LEN];
            3'd4: rd_data[1:0] = {auto_reload, ctrl_en};
            3'd5: rd_data[PRESCALE_W-1:0] = prescale;
            3'd6: rd_data = reload_period;
            3'd7: rd_data[1:0] = {wrapped, timer_timeout};
            default: rd_data = '0;
        endcase
    end
endmodule
